// File: rtl/seq_shr.sv
// Multi-cycle right shifter (logical or arithmetic) with valid/ready on both sides.
// One power-of-two shift stage is applied per clock while in SHIFT.
module seq_shr #(
   parameter int DATAWIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] sh_amt,
   input  logic                 sgn,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATAWIDTH-1:0] d
);

   localparam int STAGES = $clog2(DATAWIDTH);
   localparam int SW     = (STAGES > 1) ? $clog2(STAGES) : 1;

   localparam logic [SW-1:0]      LAST_STEP = SW'(STAGES - 1);
   localparam logic [DATAWIDTH:0] W_LIM     = (DATAWIDTH + 1)'(DATAWIDTH);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]           state;
   logic [DATAWIDTH-1:0] acc;
   logic [STAGES-1:0]    amt;
   logic [SW-1:0]        step;
   logic                 fill;
   logic                 in_fill;
   logic [DATAWIDTH-1:0] acc_nxt;

   // Out-of-range amounts saturate to a word made entirely of the fill bit.
   function automatic logic [DATAWIDTH-1:0] sat_fill(input logic f);
      return {DATAWIDTH{f}};
   endfunction

   // Applies stage s (shift by 2**s) when amount bit s is set; the double
   // inversion makes the vacated MSBs take the fill bit.
   function automatic logic [DATAWIDTH-1:0] stage_shift(
      input logic [DATAWIDTH-1:0] v,
      input logic [STAGES-1:0]    m,
      input logic [SW-1:0]        s,
      input logic                 f
   );
      logic [DATAWIDTH-1:0] r;
      r = v;
      for (int i = 0; i < STAGES; i++) begin
         if (s == SW'(i) && m[i]) begin
            r = f ? ~((~v) >> (1 << i)) : (v >> (1 << i));
         end
      end
      return r;
   endfunction

   assign in_fill  = sgn & a[DATAWIDTH-1];
   assign acc_nxt  = stage_shift(acc, amt, step, fill);
   assign in_ready = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         amt   <= '0;
         step  <= '0;
         fill  <= 1'b0;
         d     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  fill <= in_fill;
                  if ({1'b0, sh_amt} >= W_LIM) begin
                     acc   <= sat_fill(in_fill);
                     d     <= sat_fill(in_fill);
                     state <= DONE;
                  end else begin
                     acc   <= a;
                     amt   <= sh_amt[STAGES-1:0];
                     step  <= '0;
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               acc  <= acc_nxt;
               step <= step + SW'(1);
               if (step == LAST_STEP) begin
                  d     <= acc_nxt;
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_shr.sv
// Self-checking bench for seq_shr: directed cases, backpressure, reset
// abort and a randomized soak against a plain-arithmetic reference.
module tb_seq_shr;

   localparam int DW     = 32;
   localparam int STAGES = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] a = '0;
   logic [DW-1:0] sh_amt = '0;
   logic          sgn = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] d;

   int n_vec  = 0;
   int n_fail = 0;

   seq_shr #(.DATAWIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .sh_amt    (sh_amt),
      .sgn       (sgn),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] ref_shr(input logic [DW-1:0] x,
                                             input logic [DW-1:0] s,
                                             input logic          sg);
      if (s >= DW) return (sg && x[DW-1]) ? '1 : '0;
      if (sg) return DW'($signed(x) >>> s);
      return x >> s;
   endfunction

   // Drives one operand for exactly one edge (the transfer edge).
   task automatic send(input logic [DW-1:0] av, input logic [DW-1:0] sv, input logic gv);
      in_valid = 1'b1; a = av; sh_amt = sv; sgn = gv;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Edges after the transfer edge until out_valid is seen (bounded).
   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic cycle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b1; a = 32'hDEADBEEF; sh_amt = 32'd3;
      cycle(2);
      rst = 1'b0; in_valid = 1'b0;
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || d !== '0) begin
         n_fail++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b d=%h, want 1 0 00000000",
                  in_ready, out_valid, d);
      end
   endtask

   task automatic test_directed;
      logic [DW-1:0] ta [10] = '{32'hF0000000, 32'hF0000000, 32'h12345678, 32'h80000001,
                                 32'h80000001, 32'h80000000, 32'h80000000, 32'h7FFFFFF0,
                                 32'h40000000, 32'h80000001};
      logic [DW-1:0] ts [10] = '{32'd4, 32'd4, 32'd0, 32'd32, 32'hFFFFFFFF, 32'd31, 32'd31,
                                 32'd4, 32'd32, 32'hFFFFFFFF};
      logic          tg [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [DW-1:0] te [10] = '{32'h0F000000, 32'hFF000000, 32'h12345678, 32'hFFFFFFFF,
                                 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 32'h07FFFFFF,
                                 32'h00000000, 32'hFFFFFFFF};
      int lat;
      int exp_lat;
      for (int i = 0; i < 10; i++) begin
         exp_lat = (ts[i] >= DW) ? 0 : STAGES;
         n_vec++;
         if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL dir_idle_ready[%0d]: in_ready=%b want 1", i, in_ready);
         end
         send(ta[i], ts[i], tg[i]);
         n_vec++;
         if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL dir_busy_ready[%0d]: in_ready=%b want 0", i, in_ready);
         end
         wait_valid(lat);
         n_vec++;
         if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL dir_latency[%0d]: got %0d edges want %0d", i, lat, exp_lat);
         end
         n_vec++;
         if (d !== te[i]) begin
            n_fail++;
            $display("FAIL dir_result[%0d]: d=%h want %h", i, d, te[i]);
         end
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         n_vec++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0 || d !== te[i]) begin
            n_fail++;
            $display("FAIL dir_after_xfer[%0d]: in_ready=%b out_valid=%b d=%h want 1 0 %h",
                     i, in_ready, out_valid, d, te[i]);
         end
      end
   endtask

   task automatic test_backpressure;
      int lat;
      send(32'h0F0F0F0F, 32'd8, 1'b0);
      wait_valid(lat);
      in_valid = 1'b1; a = 32'hAAAAAAAA; sh_amt = 32'd1; sgn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_vec++;
         if (out_valid !== 1'b1 || d !== 32'h000F0F0F || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: out_valid=%b d=%h in_ready=%b want 1 000f0f0f 0",
                     i, out_valid, d, in_ready);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
      // The 0xAAAAAAAA operand offered during DONE must never produce a result.
      cycle(8);
      n_vec++;
      if (out_valid !== 1'b0 || d !== 32'h000F0F0F) begin
         n_fail++;
         $display("FAIL bp_no_capture: out_valid=%b d=%h want 0 000f0f0f", out_valid, d);
      end
   endtask

   task automatic test_reset_mid;
      logic seen;
      send(32'h89ABCDEF, 32'd7, 1'b1);
      cycle(2);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0 || d !== '0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid: out_valid=%b d=%h in_ready=%b want 0 00000000 1",
                  out_valid, d, in_ready);
      end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      n_vec++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_stale: out_valid seen=%b want 0", seen);
      end
   endtask

   task automatic test_random;
      logic [DW-1:0] ra, rs, exp;
      logic          rg, r, done;
      int            lat, k, exp_lat;
      for (int n = 0; n < 5000; n++) begin
         ra = $urandom;
         rg = 1'($urandom_range(0, 1));
         rs = ($urandom_range(0, 49) == 0) ? 32'hFFFFFFFF : 32'($urandom_range(0, 40));
         exp = ref_shr(ra, rs, rg);
         exp_lat = (rs >= DW) ? 0 : STAGES;
         if ($urandom_range(0, 3) == 0) cycle(1);
         send(ra, rs, rg);
         wait_valid(lat);
         n_vec++;
         if (lat != exp_lat || d !== exp) begin
            n_fail++;
            $display("FAIL rnd[%0d] a=%h sh=%0d sgn=%b: d=%h lat=%0d want %h lat=%0d",
                     n, ra, rs, rg, d, lat, exp, exp_lat);
         end
         k = 0;
         done = 1'b0;
         while (!done) begin
            r = (k >= 16) ? 1'b1 : 1'($urandom_range(0, 1));
            out_ready = r;
            @(posedge clk); #1;
            out_ready = 1'b0;
            if (r) begin
               done = 1'b1;
            end else begin
               n_vec++;
               if (out_valid !== 1'b1 || d !== exp) begin
                  n_fail++;
                  $display("FAIL rnd_stall[%0d]: out_valid=%b d=%h want 1 %h",
                           n, out_valid, d, exp);
               end
            end
            k++;
         end
         n_vec++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rnd_xfer[%0d]: out_valid=%b in_ready=%b want 0 1",
                     n, out_valid, in_ready);
         end
      end
   endtask

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
